// File: rtl/srff_bank_pkg.sv
// Shared types and arithmetic helpers for the srff_bank set/reset register bank.
package srff_pkg;

    typedef enum logic [1:0] {
        SRFF_HOLD    = 2'd0,
        SRFF_SET_DOM = 2'd1,
        SRFF_RST_DOM = 2'd2,
        SRFF_TOGGLE  = 2'd3
    } srff_mode_e;

    localparam int unsigned SRFF_MAX_CH = 64;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    // Result clamps to 2^w-1; a 65-bit sum keeps the overflow visible for w up to 64.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/srff_bank_cell.sv
// One SR channel: next-state and conflict detection for a single bit.
module srff_cell
    import srff_pkg::*;
#(
    parameter int unsigned MODE = 1
) (
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic q_cur,
    output logic q_nxt,
    output logic conflict_evt
);

    localparam logic [1:0] W_MODE_BITS = MODE[1:0];
    localparam srff_mode_e W_MODE      = srff_mode_e'(W_MODE_BITS);

    always_comb begin
        q_nxt        = q_cur;
        conflict_evt = en & s & r;
        if (en) begin
            case ({s, r})
                2'b01:   q_nxt = 1'b0;
                2'b10:   q_nxt = 1'b1;
                2'b11: begin
                    case (W_MODE)
                        SRFF_HOLD:    q_nxt = q_cur;
                        SRFF_SET_DOM: q_nxt = 1'b1;
                        SRFF_RST_DOM: q_nxt = 1'b0;
                        SRFF_TOGGLE:  q_nxt = ~q_cur;
                        default:      q_nxt = q_cur;
                    endcase
                end
                default: q_nxt = q_cur;
            endcase
        end
    end

endmodule

// File: rtl/srff_bank.sv
// Clocked multi-channel SR register bank with sticky conflict flags and saturating count.
// Optional edge pulses (rise_p/fall_p) when SRFF_BANK_EDGE_PULSE_EN is defined.
module srff_bank
    import srff_pkg::*;
#(
    parameter int unsigned   CH      = 8,
    parameter int unsigned   MODE    = 1,
    parameter int unsigned   CNT_W   = 8,
    parameter logic [CH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CH-1:0]    s,
    input  logic [CH-1:0]    r,
    input  logic             clr_err,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    qbar,
    output logic [CH-1:0]    conflict,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             any_conflict
`ifdef SRFF_BANK_EDGE_PULSE_EN
    ,
    output logic [CH-1:0]    rise_p,
    output logic [CH-1:0]    fall_p
`endif
);

    if (MODE > 3) begin : g_bad_mode
        $fatal(1, "srff_bank: MODE must be 0..3");
    end
    if (CH < 1 || CH > SRFF_MAX_CH) begin : g_bad_ch
        $fatal(1, "srff_bank: CH must be 1..64");
    end

    logic [CH-1:0]    r_q;
    logic [CH-1:0]    r_conflict;
    logic [CNT_W-1:0] r_cnt;
    logic [CH-1:0]    w_q_nxt;
    logic [CH-1:0]    w_evt;
    logic [63:0]      w_evt_ext;
    logic [63:0]      w_pop;
    logic [63:0]      w_cnt_base;
    logic [CNT_W-1:0] w_cnt_nxt;

    for (genvar i = 0; i < CH; i++) begin : g_cell
        srff_cell #(.MODE(MODE)) u_cell (
            .en           (en),
            .s            (s[i]),
            .r            (r[i]),
            .q_cur        (r_q[i]),
            .q_nxt        (w_q_nxt[i]),
            .conflict_evt (w_evt[i])
        );
    end

    // clr_err restarts the count from zero, so a same-cycle event still lands.
    always_comb begin
        w_evt_ext  = 64'(w_evt);
        w_pop      = 64'(popcount(w_evt_ext));
        w_cnt_base = clr_err ? '0 : 64'(r_cnt);
        w_cnt_nxt  = CNT_W'(sat_add(w_cnt_base, w_pop, CNT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= RST_VAL;
            r_conflict <= '0;
            r_cnt      <= '0;
        end else begin
            r_q        <= w_q_nxt;
            r_conflict <= clr_err ? w_evt : (r_conflict | w_evt);
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign q            = r_q;
    assign qbar         = ~r_q;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;
    assign any_conflict = |r_conflict;

`ifdef SRFF_BANK_EDGE_PULSE_EN
    logic [CH-1:0] r_q_d;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;

    // r_q_d tracks RST_VAL through reset so a reset-forced change never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_d  <= RST_VAL;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_q_d  <= r_q;
            r_rise <= r_q & ~r_q_d;
            r_fall <= ~r_q & r_q_d;
        end
    end

    assign rise_p = r_rise;
    assign fall_p = r_fall;
`endif

endmodule

// File: tb/tb_srff_bank.sv
// Directed self-checking bench for srff_bank across toggle, set- and reset-dominant builds.
module tb_srff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] s = '0;
    logic [7:0] r = '0;
    logic       clr_err = 1'b0;

    logic [7:0] qa, qbara, confa, ranya_unused;
    logic [7:0] cnta;
    logic       anya;
    logic [7:0] qb, qbarb, confb;
    logic [7:0] cntb;
    logic       anyb;
    logic [7:0] qc, qbarc, confc;
    logic [3:0] cntc;
    logic       anyc;
`ifdef SRFF_BANK_EDGE_PULSE_EN
    logic [7:0] risea, falla, riseb, fallb, risec, fallc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srff_bank #(.CH(8), .MODE(3), .CNT_W(8), .RST_VAL(8'hA5)) u_a (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(qa), .qbar(qbara), .conflict(confa), .conflict_cnt(cnta), .any_conflict(anya)
`ifdef SRFF_BANK_EDGE_PULSE_EN
        , .rise_p(risea), .fall_p(falla)
`endif
    );

    srff_bank #(.CH(8), .MODE(1), .CNT_W(8), .RST_VAL(8'h00)) u_b (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(qb), .qbar(qbarb), .conflict(confb), .conflict_cnt(cntb), .any_conflict(anyb)
`ifdef SRFF_BANK_EDGE_PULSE_EN
        , .rise_p(riseb), .fall_p(fallb)
`endif
    );

    srff_bank #(.CH(8), .MODE(2), .CNT_W(4), .RST_VAL(8'h00)) u_c (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(qc), .qbar(qbarc), .conflict(confc), .conflict_cnt(cntc), .any_conflict(anyc)
`ifdef SRFF_BANK_EDGE_PULSE_EN
        , .rise_p(risec), .fall_p(fallc)
`endif
    );

    assign ranya_unused = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset holds over en/s for two edges.
        rst = 1'b1; en = 1'b1; s = 8'hFF; r = 8'h00;
        step(2);
        check("rst_qa", qa, 8'hA5);
        check("rst_qbara", qbara, 8'h5A);
        check("rst_confa", confa, 8'h00);
        check("rst_cnta", cnta, 8'h00);
        check("rst_anya", anya, 1'b0);
        check("rst_qb", qb, 8'h00);

        rst = 1'b0; s = 8'h0F; r = 8'h00;
        step(1);
        check("set_qa", qa, 8'hAF);
        check("set_qb", qb, 8'h0F);

        en = 1'b0; s = 8'hFF; r = 8'hFF;
        step(3);
        check("en0_qa", qa, 8'hAF);
        check("en0_confa", confa, 8'h00);
        check("en0_cnta", cnta, 8'h00);
        check("en0_qc", qc, 8'h0F);

        en = 1'b1; s = 8'h00; r = 8'hFF;
        step(1);
        check("rstreq_qa", qa, 8'h00);
        check("rstreq_qb", qb, 8'h00);

        // Bit-0 conflict for three edges across the three modes.
        s = 8'h01; r = 8'h01;
        step(1);
        check("tog1_qa", qa, 8'h01);
        check("tog1_cnta", cnta, 8'd1);
        check("setdom1_qb", qb, 8'h01);
        step(1);
        check("tog2_qa", qa, 8'h00);
        check("tog2_cnta", cnta, 8'd2);
        step(1);
        check("tog3_qa", qa, 8'h01);
        check("tog3_confa", confa, 8'h01);
        check("tog3_cnta", cnta, 8'd3);
        check("setdom3_qb", qb, 8'h01);
        check("rstdom3_qc", qc, 8'h00);
        check("rstdom3_confc", confc, 8'h01);
        check("rstdom3_cntc", cntc, 4'd3);

        clr_err = 1'b1; s = 8'h00; r = 8'h00;
        step(1);
        check("clr_cnta", cnta, 8'd0);
        check("clr_confa", confa, 8'h00);
        check("clr_anya", anya, 1'b0);
        check("clr_cntc", cntc, 4'd0);
        check("clr_qa", qa, 8'h01);

        // All-channel conflicts: 4-bit counter saturates at 15.
        clr_err = 1'b0; s = 8'hFF; r = 8'hFF;
        step(1);
        check("sat1_cntc", cntc, 4'd8);
        check("sat1_cnta", cnta, 8'd8);
        check("sat1_qa", qa, 8'hFE);
        check("sat1_anya", anya, 1'b1);
        check("sat1_qb", qb, 8'hFF);
        step(1);
        check("sat2_cntc", cntc, 4'd15);
        check("sat2_cnta", cnta, 8'd16);
        check("sat2_qa", qa, 8'h01);
        step(1);
        check("sat3_cntc", cntc, 4'd15);
        check("sat3_cnta", cnta, 8'd24);
        check("sat3_confc", confc, 8'hFF);
        check("sat3_qc", qc, 8'h00);

        clr_err = 1'b1; s = 8'h03; r = 8'h03;
        step(1);
        check("clrevt_confa", confa, 8'h03);
        check("clrevt_cnta", cnta, 8'd2);
        check("clrevt_cntc", cntc, 4'd2);
        check("clrevt_qa", qa, 8'hFD);

        s = 8'h00; r = 8'h00;
        step(1);
        check("clr2_confa", confa, 8'h00);
        check("clr2_cnta", cnta, 8'd0);
        check("clr2_cntc", cntc, 4'd0);

        // Edge-pulse sequence on bit 2 of the MODE=1 bank, then reset to 0.
        clr_err = 1'b0; s = 8'h00; r = 8'h04;
        step(1);
        check("pl_clear_qb", qb, 8'hFB);
        s = 8'h04; r = 8'h00;
        step(1);
        check("pl_set_qb", qb, 8'hFF);
`ifdef SRFF_BANK_EDGE_PULSE_EN
        check("pl_set_fallb", fallb, 8'h04);
        check("pl_set_riseb", riseb, 8'h00);
`endif
        s = 8'h00;
        step(1);
`ifdef SRFF_BANK_EDGE_PULSE_EN
        check("pl_n1_riseb", riseb, 8'h04);
        check("pl_n1_fallb", fallb, 8'h00);
`endif
        step(1);
`ifdef SRFF_BANK_EDGE_PULSE_EN
        check("pl_n2_riseb", riseb, 8'h00);
`endif
        rst = 1'b1;
        step(1);
        check("pl_rst_qb", qb, 8'h00);
`ifdef SRFF_BANK_EDGE_PULSE_EN
        check("pl_rst_fallb", fallb, 8'h00);
`endif
        rst = 1'b0; en = 1'b0;
        step(1);
        check("pl_post_qb", qb, 8'h00);
        check("pl_post_qa", qa, 8'hA5);
`ifdef SRFF_BANK_EDGE_PULSE_EN
        check("pl_post_fallb", fallb, 8'h00);
        check("pl_post_falla", falla, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
